// File: rtl/bg_blitter.sv
// Background blitter: streams an image (or solid fill) from a synchronous ROM
// to a VGA pixel port with origin offset, screen clipping and colour keying.
module bg_blitter #(
  parameter int IMG_W    = 160,
  parameter int IMG_H    = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int C_W      = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int A_W      = 15
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic           abort,
  input  logic [X_W-1:0] x_org,
  input  logic [Y_W-1:0] y_org,
  input  logic           mode,
  input  logic [C_W-1:0] fill_colour,
  input  logic           key_en,
  input  logic [C_W-1:0] key_colour,
  output logic [A_W-1:0] rom_addr,
  input  logic [C_W-1:0] rom_q,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [C_W-1:0] colour,
  output logic           plot,
  output logic           busy,
  output logic           done
);

  typedef enum logic [1:0] {IDLE, DRAW, DRAIN, DONE} state_t;

  localparam logic [A_W-1:0] LAST_ADDR = A_W'(IMG_W * IMG_H - 1);
  localparam logic [X_W-1:0] CX_MAX    = X_W'(IMG_W - 1);

  state_t         state;
  logic           drain_cnt;
  logic [X_W-1:0] cx, cx1;
  logic [Y_W-1:0] cy, cy1;
  logic           v1;

  logic [X_W-1:0] x_org_q;
  logic [Y_W-1:0] y_org_q;
  logic           mode_q;
  logic [C_W-1:0] fill_q;
  logic           key_en_q;
  logic [C_W-1:0] key_q;

  logic           flush;
  logic [X_W:0]   x_sum;
  logic [Y_W:0]   y_sum;
  logic [C_W-1:0] pix_colour;
  logic           on_screen;
  logic           keyed;

  // Stage 1 carries cx/cy alongside the ROM read so they line up with rom_q.
  assign flush      = abort && (state == DRAW || state == DRAIN);
  assign x_sum      = {1'b0, x_org_q} + {1'b0, cx1};
  assign y_sum      = {1'b0, y_org_q} + {1'b0, cy1};
  assign pix_colour = mode_q ? fill_q : rom_q;
  assign on_screen  = (32'(x_sum) < SCREEN_W) && (32'(y_sum) < SCREEN_H);
  assign keyed      = key_en_q && (pix_colour == key_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
      rom_addr  <= '0;
      cx        <= '0;
      cy        <= '0;
      cx1       <= '0;
      cy1       <= '0;
      v1        <= 1'b0;
      x_org_q   <= '0;
      y_org_q   <= '0;
      mode_q    <= 1'b0;
      fill_q    <= '0;
      key_en_q  <= 1'b0;
      key_q     <= '0;
      x         <= '0;
      y         <= '0;
      colour    <= '0;
      plot      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      cx1    <= cx;
      cy1    <= cy;
      v1     <= (state == DRAW) && !flush;
      x      <= x_sum[X_W-1:0];
      y      <= y_sum[Y_W-1:0];
      colour <= pix_colour;
      plot   <= v1 && !flush && on_screen && !keyed;
      done   <= 1'b0;

      case (state)
        IDLE: begin
          if (start && !abort) begin
            x_org_q  <= x_org;
            y_org_q  <= y_org;
            mode_q   <= mode;
            fill_q   <= fill_colour;
            key_en_q <= key_en;
            key_q    <= key_colour;
            rom_addr <= '0;
            cx       <= '0;
            cy       <= '0;
            busy     <= 1'b1;
            state    <= DRAW;
          end
        end
        DRAW: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (rom_addr == LAST_ADDR) begin
            drain_cnt <= 1'b0;
            state     <= DRAIN;
          end else begin
            rom_addr <= rom_addr + A_W'(1);
            if (cx == CX_MAX) begin
              cx <= '0;
              cy <= cy + Y_W'(1);
            end else begin
              cx <= cx + X_W'(1);
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (drain_cnt) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bg_blitter.md
BG_BLITTER -- requirements
Module: bg_blitter

Interface
REQ-001 Parameter IMG_W, default 160, image width in pixels (1..2^X_W).
REQ-002 Parameter IMG_H, default 120, image height in pixels (1..2^Y_W).
REQ-003 Parameter X_W, default 8, x coordinate width; Y_W, default 7, y coordinate width.
REQ-004 Parameter C_W, default 3, colour width; SCREEN_W default 160, SCREEN_H default 120, clip bounds.
REQ-005 Parameter A_W, default 15, ROM address width, >= clog2(IMG_W*IMG_H).
REQ-006 clk  in  1  sole clock, all state on rising edge.
REQ-007 resetn  in  1  asynchronous active-low reset.
REQ-008 start  in  1  request a blit; sampled in IDLE only.
REQ-009 abort  in  1  synchronous cancel of a blit in progress.
REQ-010 x_org  in  X_W  screen x of image pixel (0,0); y_org  in  Y_W  screen y of image pixel (0,0).
REQ-011 mode  in  1  0 = ROM image, 1 = solid fill with fill_colour; fill_colour  in  C_W.
REQ-012 key_en  in  1  transparency enable; key_colour  in  C_W  colour that is not plotted.
REQ-013 rom_addr  out  A_W  registered ROM address; rom_q  in  C_W  ROM data, valid one cycle after address (synchronous ROM).
REQ-014 x  out  X_W, y  out  Y_W, colour  out  C_W  registered pixel to the VGA adapter; plot  out  1  pixel write strobe.
REQ-015 busy  out  1  blit in progress; done  out  1  one-cycle completion pulse.

Function
REQ-016 States IDLE, DRAW, DRAIN, DONE; IDLE->DRAW on start; DRAW->DRAIN after last address issued; DRAIN->DONE after 2 cycles; DONE->IDLE after 1 cycle.
REQ-017 On the start-accept edge, x_org, y_org, mode, fill_colour, key_en, key_colour SHALL be latched; later input changes have no effect until the next blit.
REQ-018 start outside IDLE (including DONE) SHALL be ignored; start in IDLE with abort high SHALL be ignored.
REQ-019 DRAW: image counters cx (0..IMG_W-1), cy (0..IMG_H-1) SHALL advance one pixel per cycle, raster order, cx wrap to 0 increments cy.
REQ-020 rom_addr SHALL equal cy*IMG_W+cx, held as an incrementing register (no multiplier), 0 in first DRAW cycle, IMG_W*IMG_H-1 in last.
REQ-021 Pixel for address A SHALL appear on x/y/colour with plot evaluated exactly 2 cycles after rom_addr==A; cx/cy SHALL be delayed through a matching 2-stage pipeline.
REQ-022 x = x_org+cx and y = y_org+cy, computed at X_W+1 / Y_W+1 bits; outputs take the low X_W / Y_W bits.
REQ-023 Clip: plot SHALL be 0 when the widened sum x >= SCREEN_W or y >= SCREEN_H.
REQ-024 colour SHALL be rom_q when mode=0, latched fill_colour when mode=1; latency identical in both modes.
REQ-025 Transparency: when latched key_en=1 and colour==latched key_colour, plot SHALL be 0; x/y/colour still update.
REQ-026 plot SHALL be 0 in IDLE, DONE, and for any pipeline slot not carrying a valid pixel.
REQ-027 busy SHALL be 1 from the cycle after start accept through the DONE cycle inclusive; done SHALL be 1 only in DONE.
REQ-028 Timing: with N=IMG_W*IMG_H and start accepted at edge 0, pixel 0 plot slot is cycle 3, last at cycle N+2, done at cycle N+3.
REQ-029 abort in DRAW or DRAIN SHALL return to IDLE next edge, flush the pipeline (plot 0 next cycle), busy 0, no done pulse.
REQ-030 IMG_W=1 or IMG_H=1 SHALL operate correctly (cx or cy constant 0).

Reset
REQ-031 resetn low SHALL immediately force state IDLE, rom_addr, cx, cy, pipeline, x, y, colour, plot, busy, done to 0, regardless of clock.
REQ-032 Reset deassertion mid-blit SHALL leave the block in IDLE; no done pulse and no plot until a new start.

Verification
REQ-033 IMG_W=4, IMG_H=3, origin (0,0), mode 0, ROM q=addr[2:0]: start -> 12 plots, cycles 3..14, (x,y)=(0,0)..(3,2), colour=addr mod 8, done at cycle 15 only.
REQ-034 Same params, x_org=158, y_org=119: only (158,119),(159,119) plotted; 10 pixels clipped, done still at cycle 15.
REQ-035 mode 0, key_en=1, key_colour=3: addresses 3 and 11 yield plot=0; other 10 plotted.
REQ-036 mode 1, fill_colour=5, key_en=1, key_colour=5: zero plots, done at cycle 15.
REQ-037 abort at cycle 6 -> busy 0 and plot 0 from cycle 7, no done; subsequent start completes normally.
REQ-038 resetn pulsed low between clock edges mid-blit -> all outputs 0 immediately; start held during busy ignored; default params give done at cycle 19203.
